// File: rtl/robotron_sound_cmd.sv
// -----------------------------------------------------------------------------
// robotron_sound_cmd
// Main-board-side sound command transmitter. Sound numbers from game logic are
// queued, then each is driven onto the active-low select bus PB_OUT and
// qualified by a timed active-low strobe HAND_OUT:
//   IDLE -> SETUP (PB stable) -> STROBE (HAND low) -> HOLD -> GAP (bus idle)
//
// Configuration macro: SOUND_CMD_FIFO_EN
//   defined   : 4-entry FIFO in front of the serializer
//   undefined : single holding register, one command outstanding at a time
//
// Ports:
//   clk_cpu    in   1  only clock
//   reset      in   1  asynchronous, active-high
//   cmd_valid  in   1  sound number offered
//   cmd_code   in   6  sound number, active-high (0 = accepted, discarded)
//   cmd_ready  out  1  command can be accepted this cycle
//   PB_OUT     out  6  select bus, active-low, 6'h3F = no sound (flop)
//   HAND_OUT   out  1  strobe, active-low (flop)
//   busy       out  1  serializer not idle or a command is pending
// -----------------------------------------------------------------------------
module robotron_sound_cmd #(
  parameter int unsigned SETUP_CYCLES  = 4,
  parameter int unsigned STROBE_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned GAP_CYCLES    = 64
) (
  input  logic       clk_cpu,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [5:0] cmd_code,
  output logic       cmd_ready,
  output logic [5:0] PB_OUT,
  output logic       HAND_OUT,
  output logic       busy
);

  localparam int unsigned CODE_W = 6;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_push;
  logic                w_pop;
  logic                w_pending;
  logic [CODE_W-1:0]   w_head;

`ifdef SOUND_CMD_FIFO_EN
  localparam int unsigned FIFO_DEPTH = 4;

  logic [CODE_W-1:0] r_mem [FIFO_DEPTH];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [2:0]        r_count;

  // Ready depends only on the registered count; a same-cycle pop never
  // makes room for a push when full.
  assign cmd_ready = (r_count != 3'(FIFO_DEPTH));
  assign w_pending = (r_count != 3'd0);
  assign w_head    = r_mem[r_rd_ptr];

  // Queue storage, pointers and occupancy
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= cmd_code;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic              r_hold_valid;
  logic [CODE_W-1:0] r_hold_code;

  // Only one command in flight: ready again once the serializer is back in
  // IDLE and nothing is held.
  assign cmd_ready = (r_state == S_IDLE) && !r_hold_valid;
  assign w_pending = r_hold_valid;
  assign w_head    = r_hold_code;

  // Single holding register
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      r_hold_valid <= 1'b0;
      r_hold_code  <= '0;
    end else if (w_push) begin
      r_hold_valid <= 1'b1;
      r_hold_code  <= cmd_code;
    end else if (w_pop) begin
      r_hold_valid <= 1'b0;
    end
  end
`endif

  // Code 0 is consumed by the handshake but never queued.
  assign w_push = cmd_valid && cmd_ready && (cmd_code != 6'd0);
  assign w_pop  = (r_state == S_IDLE) && w_pending;
  assign busy   = (r_state != S_IDLE) || w_pending;

  // Serializer FSM; one shared down-counter loaded with N-1 on state entry
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      PB_OUT   <= 6'h3F;
      HAND_OUT <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          PB_OUT   <= 6'h3F;
          HAND_OUT <= 1'b1;
          if (w_pop) begin
            PB_OUT  <= ~w_head;
            r_cnt   <= CNT_W'(SETUP_CYCLES - 1);
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            HAND_OUT <= 1'b0;
            r_cnt    <= CNT_W'(STROBE_CYCLES - 1);
            r_state  <= S_STROBE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_STROBE: begin
          if (r_cnt == '0) begin
            HAND_OUT <= 1'b1;
            r_cnt    <= CNT_W'(HOLD_CYCLES - 1);
            r_state  <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            PB_OUT  <= 6'h3F;
            r_cnt   <= CNT_W'(GAP_CYCLES - 1);
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          PB_OUT   <= 6'h3F;
          HAND_OUT <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_robotron_sound_cmd.sv
// -----------------------------------------------------------------------------
// tb_robotron_sound_cmd
// Directed bench for robotron_sound_cmd (default timing parameters). Follows
// SOUND_CMD_FIFO_EN so the same file covers both queue variants. A negedge
// monitor logs every HAND_OUT falling edge with its cycle number and PB_OUT.
// -----------------------------------------------------------------------------
module tb_robotron_sound_cmd;

  logic       clk_cpu = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [5:0] cmd_code;
  logic       cmd_ready;
  logic [5:0] PB_OUT;
  logic       HAND_OUT;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int         fall_cyc[$];
  logic [5:0] fall_pb[$];
  logic       prev_hand = 1'b1;

  robotron_sound_cmd dut (
    .clk_cpu   (clk_cpu),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_ready (cmd_ready),
    .PB_OUT    (PB_OUT),
    .HAND_OUT  (HAND_OUT),
    .busy      (busy)
  );

  always #5 clk_cpu = ~clk_cpu;

  always @(posedge clk_cpu) cyc <= cyc + 1;

  // Strobe log: cycle index of the edge that pulled HAND_OUT low
  always @(negedge clk_cpu) begin
    if (prev_hand && !HAND_OUT) begin
      fall_cyc.push_back(cyc);
      fall_pb.push_back(PB_OUT);
    end
    prev_hand <= HAND_OUT;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_cpu);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      step(1);
      n++;
    end
    chk(tag, 32'(n < max_cyc), 32'd1);
  endtask

  initial begin
    int   a;
    int   base;
    int   n;
    int   bad;
    int   accepted;
    logic rdy;
    logic saw_not_ready;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_code  = 6'd0;

    // ---- reset values
    step(3);
    chk("rst_pb",    32'(PB_OUT),    32'h3F);
    chk("rst_hand",  32'(HAND_OUT),  32'd1);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy",  32'(busy),      32'd0);
    reset = 1'b0;
    step(2);

    // ---- single command 2A, accepted at edge a
    base      = fall_cyc.size();
    cmd_valid = 1'b1;
    cmd_code  = 6'h2A;
    step(1);
    a         = cyc;
    cmd_valid = 1'b0;
    chk("s_busy_k",  32'(busy),   32'd1);
    chk("s_pb_k",    32'(PB_OUT), 32'h3F);
`ifdef SOUND_CMD_FIFO_EN
    chk("s_ready_k", 32'(cmd_ready), 32'd1);
`else
    chk("s_ready_k", 32'(cmd_ready), 32'd0);
`endif
    step(1);  // a+1
    chk("s_pb_k1",     32'(PB_OUT),   32'h15);
    chk("s_hand_k1",   32'(HAND_OUT), 32'd1);
    step(3);  // a+4
    chk("s_hand_k4",   32'(HAND_OUT), 32'd1);
    step(1);  // a+5
    chk("s_hand_k5",   32'(HAND_OUT), 32'd0);
    step(7);  // a+12
    chk("s_hand_k12",  32'(HAND_OUT), 32'd0);
    chk("s_pb_k12",    32'(PB_OUT),   32'h15);
    step(1);  // a+13
    chk("s_hand_k13",  32'(HAND_OUT), 32'd1);
    step(15); // a+28
    chk("s_pb_k28",    32'(PB_OUT),   32'h15);
    step(1);  // a+29
    chk("s_pb_k29",    32'(PB_OUT),   32'h3F);
    step(63); // a+92
    chk("s_busy_k92",  32'(busy),     32'd1);
`ifndef SOUND_CMD_FIFO_EN
    chk("s_ready_k92", 32'(cmd_ready), 32'd0);
`endif
    step(1);  // a+93
    chk("s_busy_k93",  32'(busy),      32'd0);
    chk("s_ready_k93", 32'(cmd_ready), 32'd1);
    chk("s_nfall",     32'(fall_cyc.size() - base), 32'd1);
    if (fall_cyc.size() > base) chk("s_fall_cyc", 32'(fall_cyc[base] - a), 32'd5);

    // ---- code 0: accepted, no bus activity
    step(2);
    base      = fall_cyc.size();
    chk("z_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_code  = 6'h00;
    step(1);
    cmd_valid = 1'b0;
    bad       = 0;
    for (int i = 0; i < 100; i++) begin
      if (PB_OUT !== 6'h3F || HAND_OUT !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) bad++;
      step(1);
    end
    chk("z_quiet", 32'(bad), 32'd0);
    chk("z_nfall", 32'(fall_cyc.size() - base), 32'd0);

    // ---- reset during STROBE of 3F
    cmd_valid = 1'b1;
    cmd_code  = 6'h3F;
    step(1);
`ifdef SOUND_CMD_FIFO_EN
    cmd_code  = 6'h05;  // second entry left in the queue
    step(1);
    cmd_valid = 1'b0;
    step(4);            // a+5
`else
    cmd_valid = 1'b0;
    step(5);            // a+5
`endif
    chk("r_hand_strobe", 32'(HAND_OUT), 32'd0);
    chk("r_pb_strobe",   32'(PB_OUT),   32'h00);
    #2;
    reset = 1'b1;
    #1;
    chk("r_hand_async", 32'(HAND_OUT), 32'd1);
    chk("r_pb_async",   32'(PB_OUT),   32'h3F);
    chk("r_busy_async", 32'(busy),     32'd0);
    step(1);
    reset = 1'b0;
    base  = fall_cyc.size();
    step(20);
    chk("r_busy_after", 32'(busy),      32'd0);
    chk("r_ready_after",32'(cmd_ready), 32'd1);
    chk("r_pb_after",   32'(PB_OUT),    32'h3F);
    chk("r_nfall",      32'(fall_cyc.size() - base), 32'd0);

`ifdef SOUND_CMD_FIFO_EN
    // ---- six back-to-back commands 1..6, valid held high
    base          = fall_cyc.size();
    accepted      = 0;
    saw_not_ready = 1'b0;
    n             = 0;
    a             = 0;
    cmd_valid     = 1'b1;
    cmd_code      = 6'd1;
    while (accepted < 6 && n < 1000) begin
      rdy = cmd_ready;
      if (!rdy) saw_not_ready = 1'b1;
      step(1);
      n++;
      if (rdy) begin
        accepted++;
        if (accepted == 1) a = cyc;
        cmd_code = 6'(accepted + 1);
      end
    end
    cmd_valid = 1'b0;
    chk("b_accepted",  32'(accepted),      32'd6);
    chk("b_backpress", 32'(saw_not_ready), 32'd1);
    wait_idle(1000, "b_idle_timeout");
    chk("b_nfall", 32'(fall_cyc.size() - base), 32'd6);
    if (fall_cyc.size() - base == 6) begin
      chk("b_first_fall", 32'(fall_cyc[base] - a), 32'd5);
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("b_pb%0d", i), 32'(fall_pb[base + i]), 32'(~6'(i + 1)));
        if (i > 0) chk($sformatf("b_period%0d", i),
                       32'(fall_cyc[base + i] - fall_cyc[base + i - 1]), 32'd93);
      end
    end
`else
    // ---- two commands through the holding register
    base      = fall_cyc.size();
    cmd_valid = 1'b1;
    cmd_code  = 6'd1;
    step(1);
    a         = cyc;
    cmd_code  = 6'd2;
    n         = 0;
    while (cmd_ready !== 1'b1 && n < 300) begin
      step(1);
      n++;
    end
    chk("t_ready_wait", 32'(n), 32'd93);
    step(1);
    cmd_valid = 1'b0;
    chk("t_ready_after2", 32'(cmd_ready), 32'd0);
    wait_idle(300, "t_idle_timeout");
    chk("t_nfall", 32'(fall_cyc.size() - base), 32'd2);
    if (fall_cyc.size() - base == 2) begin
      chk("t_first_fall", 32'(fall_cyc[base] - a), 32'd5);
      chk("t_pb0", 32'(fall_pb[base]),     32'h3E);
      chk("t_pb1", 32'(fall_pb[base + 1]), 32'h3D);
      chk("t_spacing", 32'((fall_cyc[base + 1] - fall_cyc[base]) >= 93), 32'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
